// File: rtl/vending_pkg.sv
// Shared definitions for the multi-product vending controller: coin values,
// FSM state encoding and helpers for decoding coins and extracting prices.
package vending_pkg;

    // Coin values in units of 5c
    localparam logic [2:0] COIN_VAL_1 = 3'd1;
    localparam logic [2:0] COIN_VAL_2 = 3'd2;
    localparam logic [2:0] COIN_VAL_5 = 3'd5;

    // Upper bounds used to size the generic price-extraction helper
    localparam int MAX_ITEMS    = 16;
    localparam int MAX_CREDIT_W = 32;
    localparam int PRICE_VEC_W  = MAX_ITEMS * MAX_CREDIT_W;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        VEND,
        CHANGE
    } state_t;

    // Unit value of a coin strobe; 0 when the strobe is not one-hot
    function automatic logic [2:0] coin_value(input logic [2:0] coin);
        case (coin)
            3'b001:  return COIN_VAL_1;
            3'b010:  return COIN_VAL_2;
            3'b100:  return COIN_VAL_5;
            default: return 3'd0;
        endcase
    endfunction

    // Price of slot idx from a packed price vector with credit_w bits per slot
    function automatic logic [MAX_CREDIT_W-1:0] price_at(
        input logic [PRICE_VEC_W-1:0] prices,
        input int unsigned            idx,
        input int unsigned            credit_w
    );
        logic [PRICE_VEC_W-1:0]  shifted;
        logic [MAX_CREDIT_W-1:0] mask;
        shifted = prices >> (idx * credit_w);
        mask    = (MAX_CREDIT_W'(1) << credit_w) - MAX_CREDIT_W'(1);
        return shifted[MAX_CREDIT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Front-end bus of the vending controller: coin/keypad requests in,
// dispenser, change and status signals out. Parameters must match the
// controller instance attached to the slave modport.
interface vending_machine_multi_if #(
    parameter int NUM_ITEMS = 4,
    parameter int SEL_W     = 2,
    parameter int CREDIT_W  = 8
);
    logic [2:0]           coin;
    logic                 sel_valid;
    logic [SEL_W-1:0]     selection;
    logic                 cancel;
    logic                 restock;
    logic [NUM_ITEMS-1:0] dispense;
    logic                 change_valid;
    logic [CREDIT_W-1:0]  change;
    logic [CREDIT_W-1:0]  credit;
    logic [NUM_ITEMS-1:0] sold_out;
    logic                 coin_reject;
    logic                 sel_error;

    // Front end: drives requests, observes controller outputs
    modport master (
        output coin, sel_valid, selection, cancel, restock,
        input  dispense, change_valid, change, credit, sold_out,
               coin_reject, sel_error
    );

    // Controller side
    modport slave (
        input  coin, sel_valid, selection, cancel, restock,
        output dispense, change_valid, change, credit, sold_out,
               coin_reject, sel_error
    );
endinterface

// File: rtl/vend_stock_counter.sv
// Per-slot stock counter: loads INIT_STOCK on reset or restock, decrements
// on a vend and never wraps below zero.
module vend_stock_counter #(
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic empty
);
    logic [STOCK_W-1:0] count;

    // Stock register: reload has priority over a same-cycle decrement
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= STOCK_W'(INIT_STOCK);
        end else if (load) begin
            count <= STOCK_W'(INIT_STOCK);
        end else if (dec && (count != '0)) begin
            count <= count - STOCK_W'(1);
        end
    end

    assign empty = (count == '0);
endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: accumulates coin credit, vends the
// selected slot when credit and stock allow, refunds the balance as change
// and reports sold-out slots. All outputs are registered.
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int                          NUM_ITEMS  = 4,
    parameter int                          SEL_W      = 2,
    parameter int                          CREDIT_W   = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES   = {8'd5, 8'd4, 8'd3, 8'd2},
    parameter int                          STOCK_W    = 4,
    parameter int                          INIT_STOCK = 5
) (
    input logic                    clk,
    input logic                    reset,
    vending_machine_multi_if.slave bus
);
    localparam int SLOTS_P2 = 1 << SEL_W;

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [CREDIT_W-1:0]  change_q, change_d;
    logic                 change_valid_q, change_valid_d;
    logic [NUM_ITEMS-1:0] dispense_q, dispense_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 sel_error_q, sel_error_d;

    logic [NUM_ITEMS-1:0] sold_out;
    logic [SLOTS_P2-1:0]  sold_out_pad;
    logic [NUM_ITEMS-1:0] dec_vec;
    logic                 load_stock;

    logic [2:0]           coin_val;
    logic                 coin_present;
    logic [CREDIT_W:0]    coin_sum;
    logic                 coin_ok;
    logic [CREDIT_W-1:0]  credit_add;
    logic [CREDIT_W-1:0]  price_sel;
    logic                 sel_in_range;
    logic                 sel_ok;
    logic                 accept_sel;

    // Coin decode and overflow check against the current credit
    always_comb begin
        coin_val     = coin_value(bus.coin);
        coin_present = |bus.coin;
        coin_sum     = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
        coin_ok      = (coin_val != 3'd0) && !coin_sum[CREDIT_W];
        credit_add   = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
    end

    // Price mux and selection qualification (range, stock, credit)
    always_comb begin
        sold_out_pad = SLOTS_P2'(sold_out);
        price_sel    = CREDIT_W'(price_at(PRICE_VEC_W'(PRICES), 32'(bus.selection), CREDIT_W));
        sel_in_range = {1'b0, bus.selection} < (SEL_W+1)'(NUM_ITEMS);
        sel_ok       = sel_in_range && !sold_out_pad[bus.selection] && (credit_q >= price_sel);
    end

    // Next-state and next-output logic
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = '0;
        change_valid_d = 1'b0;
        dispense_d     = '0;
        coin_reject_d  = 1'b0;
        sel_error_d    = 1'b0;
        accept_sel     = 1'b0;

        case (state_q)
            IDLE, CREDIT: begin
                coin_reject_d = coin_present && !coin_ok;
                if (bus.cancel && (state_q == CREDIT)) begin
                    change_d       = credit_add;
                    change_valid_d = 1'b1;
                    credit_d       = '0;
                    state_d        = CHANGE;
                end else if (bus.sel_valid && sel_ok) begin
                    accept_sel = 1'b1;
                    dispense_d = NUM_ITEMS'(1) << bus.selection;
                    credit_d   = credit_add - price_sel;
                    state_d    = VEND;
                end else begin
                    sel_error_d = bus.sel_valid;
                    credit_d    = credit_add;
                    state_d     = (credit_add != '0) ? CREDIT : IDLE;
                end
            end
            VEND: begin
                coin_reject_d = coin_present;
                if (credit_q != '0) begin
                    change_d       = credit_q;
                    change_valid_d = 1'b1;
                    credit_d       = '0;
                    state_d        = CHANGE;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_present;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops credit without a refund
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            dispense_q     <= '0;
            coin_reject_q  <= 1'b0;
            sel_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            dispense_q     <= dispense_d;
            coin_reject_q  <= coin_reject_d;
            sel_error_q    <= sel_error_d;
        end
    end

    assign load_stock = bus.restock && (state_q == IDLE);
    assign dec_vec    = accept_sel ? (NUM_ITEMS'(1) << bus.selection) : '0;

    // One stock counter per product slot
    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_slot
        vend_stock_counter #(
            .STOCK_W    (STOCK_W),
            .INIT_STOCK (INIT_STOCK)
        ) u_stock (
            .clk   (clk),
            .reset (reset),
            .load  (load_stock),
            .dec   (dec_vec[i]),
            .empty (sold_out[i])
        );
    end

    assign bus.dispense     = dispense_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change       = change_q;
    assign bus.credit       = credit_q;
    assign bus.sold_out     = sold_out;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.sel_error    = sel_error_q;
endmodule

// File: doc/vending_machine_multi.md
# vending_machine_multi

Parametrised successor to the single-product vending controller. It sells `NUM_ITEMS` products, each with its own price and stock count. It accumulates coin credit, refunds the balance as change after a sale or on cancel, and flags sold-out slots. It sits between the coin acceptor / keypad front end and the dispenser solenoid drivers.

## Interface
Parameters:
- `NUM_ITEMS`, 4: number of product slots (2..16).
- `SEL_W`, 2: selection index width; must satisfy 2^SEL_W >= NUM_ITEMS.
- `CREDIT_W`, 8: credit, price and change width, in units of 5c.
- `PRICES`, {8'd5,8'd4,8'd3,8'd2}: packed NUM_ITEMS×CREDIT_W price vector; slot i is `PRICES[i*CREDIT_W +: CREDIT_W]`.
- `STOCK_W`, 4: per-slot stock counter width.
- `INIT_STOCK`, 5: stock loaded at reset and on restock.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `coin`  in  3  one-hot coin strobe, one cycle per coin. Bit 0 = 1 unit (5c), bit 1 = 2 units (10c), bit 2 = 5 units (25c).
- `sel_valid`  in  1  selection strobe.
- `selection`  in  SEL_W  slot index, sampled when `sel_valid` = 1.
- `cancel`  in  1  refund request.
- `restock`  in  1  reload all slots to `INIT_STOCK`.
- `dispense`  out  NUM_ITEMS  one-hot, one-cycle vend pulse.
- `change_valid`  out  1  one-cycle pulse marking a valid `change` value.
- `change`  out  CREDIT_W  refund amount; 0 when `change_valid` = 0.
- `credit`  out  CREDIT_W  current accumulated credit.
- `sold_out`  out  NUM_ITEMS  level; bit i = 1 when stock[i] == 0.
- `coin_reject`  out  1  one-cycle pulse: coin was not accepted.
- `sel_error`  out  1  one-cycle pulse: selection was refused.

## Operation
- States:
  - IDLE: credit == 0.
  - CREDIT: credit > 0.
  - VEND: one cycle, `dispense` asserted.
  - CHANGE: one cycle, `change_valid` asserted.
- Coin accepted in IDLE/CREDIT only: credit += value, then IDLE→CREDIT.
- Coin rejected (`coin_reject` = 1, credit unchanged) when any of these holds:
  - `coin` is not one-hot;
  - credit + value would exceed 2^CREDIT_W−1;
  - the FSM is in VEND or CHANGE.
- Selection in CREDIT is refused (`sel_error` = 1, no state change) when any of these holds:
  - `selection` >= NUM_ITEMS;
  - sold_out[sel] = 1;
  - credit < price.
- Selection in IDLE follows the same rule. A price-0 slot vends from IDLE.
- Accepted selection → VEND:
  - `dispense[sel]` = 1;
  - stock[sel] −= 1;
  - credit −= price.
- After VEND: if the remaining credit is > 0, go to CHANGE; otherwise go to IDLE.
- CHANGE: `change` = credit, `change_valid` = 1, credit → 0, then IDLE.
- `cancel` in CREDIT → CHANGE with the full credit. `cancel` in IDLE is ignored (no change pulse).
- Priority within one cycle: `cancel` > selection. A coin in the same cycle as an accepted selection or cancel is still accepted, and its value is included in the refund.
- `restock` is honoured only in IDLE. Elsewhere it is ignored silently.
- `sel_valid`/`cancel` during VEND or CHANGE are ignored (no `sel_error`).
- Stock never goes below 0. A sold-out slot cannot vend.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE;
  - credit 0;
  - `dispense`, `change`, `change_valid`, `coin_reject`, `sel_error` = 0;
  - every stock = INIT_STOCK;
  - `sold_out` = 0 if INIT_STOCK > 0.
- Coin strobed in cycle t → `credit` updated at t+1.
- Accepted selection at t → `dispense` at t+1 → `change_valid` at t+2 (if credit remains) → IDLE at t+3.
- Cancel at t → `change_valid` at t+1.
- `sold_out` updates in the same cycle as the `dispense` pulse that empties the slot.
- Reset asserted mid-VEND or mid-CHANGE: outputs clear immediately. Credit is lost and no refund is issued. Stock is reloaded.
- Error pulses are asserted in cycle t+1 for stimulus at t.

## Structure
- Package `vending_pkg`:
  - coin-value constants (1, 2, 5 units);
  - state enum (IDLE, CREDIT, VEND, CHANGE);
  - a price-extraction function.
- Sub-module `vend_stock_counter`: one per slot via generate. It provides load-on-reset/restock and a decrement-with-floor, and outputs `empty`.
- Top: FSM, credit adder with overflow check, price mux, output registers.

## Test plan
- Two 5-unit coins, select slot 3 (price 5) → `credit` 10; `dispense` = 4'b1000 one cycle; next cycle `change_valid` = 1, `change` = 5; `credit` 0.
- 2 units, select slot 2 (price 4) → `sel_error` pulse, no dispense, credit stays 2. Then `cancel` → `change` = 2.
- Vend slot 0 six times with INIT_STOCK = 5 → `sold_out[0]` rises with the 5th `dispense`. The 6th select gives `sel_error`; the remaining credit is still refundable.
- Credit 254, insert 5-unit coin → `coin_reject`, credit stays 254. Coin = 3'b011 → `coin_reject`.
- Coin 2 units in the same cycle as an accepted select of slot 0 with credit 2 → dispense slot 0, `change` = 2.
- Drop `reset` during VEND → all outputs 0 at once, stock = 5 everywhere, state IDLE. `restock` during CREDIT → ignored.
